mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: DW, 32, data and address width.
REQ-002 Parameter: RW, 5, register-index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req0/req1  input  1  memory request from slot 0 / slot 1 (slot 0 is older in program order).
REQ-006 en1  input  1  slot-1 issue enable; req1 SHALL be ignored when en1=0.
REQ-007 we0/we1  input  1  1=store, 0=load.
REQ-008 addr0/addr1  input  DW  byte address.
REQ-009 wdata0/wdata1  input  DW  store data.
REQ-010 rd0/rd1  input  RW  load destination register.
REQ-011 mem_en, mem_we  output  1  single-port data-memory strobe and write enable.
REQ-012 mem_addr, mem_wdata  output  DW  memory address and write data.
REQ-013 mem_rdata  input  DW  read data, valid exactly 1 cycle after a load strobe.
REQ-014 stall  output  1  freeze fetch/decode/issue for the current cycle.
REQ-015 wb_valid  output  1  load write-back valid; wb_port  output  1  originating slot.
REQ-016 wb_reg  output  RW; wb_data  output  DW  load destination and data.
REQ-017 conflict_cnt  output  16  count of dual-request conflicts.

Function
REQ-018 FSM states SHALL be IDLE and SECOND.
REQ-019 IDLE, exactly one effective request: SHALL drive it to memory the same cycle (combinational), stall=0, remain IDLE.
REQ-020 IDLE, both effective requests: SHALL drive slot 0 to memory, capture slot-1 fields into a hold register, assert stall combinationally, go to SECOND.
REQ-021 SECOND: SHALL drive the held slot-1 request to memory, stall=0, ignore req0/req1 (upstream re-presents the frozen pair), return to IDLE.
REQ-022 No effective request: mem_en=0; mem_addr, mem_wdata and mem_we SHALL be 0.
REQ-023 Every load strobe SHALL produce wb_valid=1 in the following cycle, with wb_reg and wb_port registered from the issuing request and wb_data=mem_rdata; stores produce no write-back.
REQ-024 Serialization SHALL preserve slot-0-before-slot-1 order, so a store-to-load pair on the same address returns the stored value.
REQ-025 conflict_cnt SHALL increment on each IDLE->SECOND transition and saturate at 16'hFFFF.
REQ-026 Store latency: 0 cycles (single request) or 1 cycle (held slot 1). Load-to-write-back latency: 1 or 2 cycles.

Reset
REQ-027 With rst=1 at a clock edge, state SHALL become IDLE and the hold register, wb_valid, wb_port, wb_reg, wb_data and conflict_cnt SHALL become 0.
REQ-028 rst in SECOND SHALL discard the held request, and no memory access SHALL be issued for it.
REQ-029 rst SHALL suppress the write-back of a load strobed in the cycle before reset.
REQ-030 While rst=1, mem_en and stall SHALL be 0.

Structure
REQ-031 Shared package pap_pkg SHALL hold the state enum (IDLE, SECOND), DW/RW defaults, and a request struct (we, addr, wdata, rd).
REQ-032 One sub-module, mem_req_reg, SHALL implement the single-entry request hold register with load and clear.
REQ-033 Request muxing, stall and FSM SHALL stay in mem_arb.

Verification
REQ-034 req0 load addr 0x10, rd0=3, mem[0x10]=0xA5 -> mem_en same cycle, no stall; next cycle wb_valid=1, wb_port=0, wb_reg=3, wb_data=0xA5.
REQ-035 req0 store 0x20<=0x11 and req1 load 0x20 (rd1=7) together, en1=1 -> stall=1 in cycle N, store in N, load in N+1; wb_data=0x11 and wb_reg=7 in N+2; conflict_cnt=1.
REQ-036 Same pair with en1=0 -> only the slot-0 store is issued, stall=0, conflict_cnt unchanged.
REQ-037 Dual request, then rst=1 in the SECOND cycle -> no slot-1 access, wb_valid=0, conflict_cnt=0 on the next cycle.
REQ-038 Force conflict_cnt to 16'hFFFE, then two conflicts -> 16'hFFFF, and it holds at 16'hFFFF.
REQ-039 Back-to-back single loads from slot 1 on 3 cycles -> 3 consecutive wb_valid pulses with wb_port=1 and no stall.

Source files
------------

// File: rtl/pap_pkg.sv
// Shared types for the dual-slot data-memory arbiter.
// Provides the arbiter FSM states, default widths and the request bundle.
package pap_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic [DW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
    logic [RW_DEF-1:0] rd;
  } req_t;

endpackage

// File: rtl/mem_req_reg.sv
// Single-entry request hold register with synchronous load and clear.
// Ports: clk, rst, clr, load, d (request in), q (held request out).
module mem_req_reg
  import pap_pkg::*;
#(
  parameter type T = req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Serializes two issue slots onto one single-port data memory.
// Ports: slot 0/1 requests in, mem_* strobe out, stall, load write-back, conflict count.
module mem_arb
  import pap_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          en1,
  input  logic          we0,
  input  logic          we1,
  input  logic [DW-1:0] addr0,
  input  logic [DW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [RW-1:0] rd0,
  input  logic [RW-1:0] rd1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          wb_valid,
  output logic          wb_port,
  output logic [RW-1:0] wb_reg,
  output logic [DW-1:0] wb_data,
  output logic [15:0]   conflict_cnt
);

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [RW-1:0] rd;
  } areq_t;

  state_t state_q, state_d;
  areq_t  r0, r1, held, sel;
  logic   eff0, eff1;
  logic   sel_vld, sel_port;
  logic   hold_load, hold_clr;
  logic   is_load;
  logic [15:0] cnt_q;

  assign eff0 = req0;
  assign eff1 = req1 & en1;

  assign r0 = '{we: we0, addr: addr0, wdata: wdata0, rd: rd0};
  assign r1 = '{we: we1, addr: addr1, wdata: wdata1, rd: rd1};

  mem_req_reg #(.T(areq_t)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (hold_clr),
    .load (hold_load),
    .d    (r1),
    .q    (held)
  );

  always_comb begin
    state_d   = state_q;
    sel       = '0;
    sel_vld   = 1'b0;
    sel_port  = 1'b0;
    stall     = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          eff0 && eff1: begin
            sel       = r0;
            sel_vld   = 1'b1;
            stall     = 1'b1;
            hold_load = 1'b1;
            state_d   = SECOND;
          end
          eff0 && !eff1: begin
            sel     = r0;
            sel_vld = 1'b1;
          end
          !eff0 && eff1: begin
            sel      = r1;
            sel_vld  = 1'b1;
            sel_port = 1'b1;
          end
          default: ;
        endcase
      end
      SECOND: begin
        // req0/req1 carry the frozen pair here; only the hold matters
        sel      = held;
        sel_vld  = 1'b1;
        sel_port = 1'b1;
        hold_clr = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset kills any access in flight, including a held slot-1 request
    if (rst) begin
      sel       = '0;
      sel_vld   = 1'b0;
      sel_port  = 1'b0;
      stall     = 1'b0;
      hold_load = 1'b0;
      state_d   = IDLE;
    end
  end

  assign mem_en    = sel_vld;
  assign mem_we    = sel.we;
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;

  assign is_load = sel_vld & ~sel.we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wb_valid <= 1'b0;
      wb_port  <= 1'b0;
      wb_reg   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wb_valid <= is_load;
      if (is_load) begin
        wb_port <= sel_port;
        wb_reg  <= sel.rd;
      end
      if (hold_load && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Read data arrives one cycle after the strobe, aligned with wb_valid
  assign wb_data      = wb_valid ? mem_rdata : '0;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb against an order-based reference model.
// Drives request bundles, models memory, checks strobes, stall, write-back, count.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, en1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic [4:0]  rd0 = 0, rd1 = 0;
  logic        mem_en, mem_we, stall, wb_valid, wb_port;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [31:0] mem_rdata = 0;
  logic [4:0]  wb_reg;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] tmem [0:255] = '{default: 32'h0};
  logic [31:0] rmem [0:255] = '{default: 32'h0};

  logic        exp_wbv = 0;
  logic        exp_port = 0;
  logic [4:0]  exp_reg = 0;
  logic [31:0] exp_data = 0;
  int          exp_cnt = 0;

  logic        b_r0, b_r1, b_e1, b_w0, b_w1;
  logic [31:0] b_a0, b_a1, b_d0, b_d1;
  logic [4:0]  b_g0, b_g1;

  mem_arb dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .en1(en1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .rd0(rd0), .rd1(rd1),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_port(wb_port),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tmem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= tmem[mem_addr[7:0]];
    end
  end

  task automatic set_b(input logic r0, r1, e1, w0, w1,
                       input logic [31:0] a0, a1, d0, d1,
                       input logic [4:0] g0, g1);
    b_r0 = r0; b_r1 = r1; b_e1 = e1; b_w0 = w0; b_w1 = w1;
    b_a0 = a0; b_a1 = a1; b_d0 = d0; b_d1 = d1;
    b_g0 = g0; b_g1 = g1;
  endtask

  // One bundle: the ordered list of accesses is what the memory must see.
  task automatic run_bundle();
    int          n;
    int          cyc;
    logic        owe [2];
    logic        opt [2];
    logic [31:0] oa [2];
    logic [31:0] ow [2];
    logic [4:0]  org [2];
    n = 0;
    if (b_r0) begin
      owe[n] = b_w0; oa[n] = b_a0; ow[n] = b_d0; org[n] = b_g0; opt[n] = 0;
      n++;
    end
    if (b_r1 && b_e1) begin
      owe[n] = b_w1; oa[n] = b_a1; ow[n] = b_d1; org[n] = b_g1; opt[n] = 1;
      n++;
    end
    cyc = (n == 0) ? 1 : n;
    for (int i = 0; i < cyc; i++) begin
      checks++;
      if (wb_valid !== exp_wbv) begin
        errors++;
        $display("FAIL wb_valid got %0b want %0b t=%0t", wb_valid, exp_wbv, $time);
      end
      if (exp_wbv) begin
        checks++;
        if (wb_port !== exp_port || wb_reg !== exp_reg || wb_data !== exp_data) begin
          errors++;
          $display("FAIL wb got port=%0b reg=%0d data=%h want port=%0b reg=%0d data=%h",
                   wb_port, wb_reg, wb_data, exp_port, exp_reg, exp_data);
        end
      end
      checks++;
      if (conflict_cnt !== exp_cnt[15:0]) begin
        errors++;
        $display("FAIL conflict_cnt got %h want %h", conflict_cnt, exp_cnt[15:0]);
      end
      if (i == 0) begin
        req0 = b_r0; req1 = b_r1; en1 = b_e1; we0 = b_w0; we1 = b_w1;
        addr0 = b_a0; addr1 = b_a1; wdata0 = b_d0; wdata1 = b_d1;
        rd0 = b_g0; rd1 = b_g1;
      end else begin
        req0 = 1'($urandom); req1 = 1'($urandom); en1 = 1'($urandom);
        we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = $urandom; addr1 = $urandom;
        wdata0 = $urandom; wdata1 = $urandom;
        rd0 = 5'($urandom); rd1 = 5'($urandom);
      end
      #1;
      checks++;
      if (n == 0) begin
        if (mem_en !== 0 || mem_we !== 0 || mem_addr !== 0 ||
            mem_wdata !== 0 || stall !== 0) begin
          errors++;
          $display("FAIL idle_bus got en=%0b we=%0b a=%h d=%h st=%0b want all 0",
                   mem_en, mem_we, mem_addr, mem_wdata, stall);
        end
      end else begin
        if (mem_en !== 1 || mem_we !== owe[i] || mem_addr !== oa[i] ||
            (owe[i] && mem_wdata !== ow[i]) ||
            stall !== (n == 2 && i == 0)) begin
          errors++;
          $display("FAIL access%0d got en=%0b we=%0b a=%h d=%h st=%0b want en=1 we=%0b a=%h d=%h st=%0b",
                   i, mem_en, mem_we, mem_addr, mem_wdata, stall,
                   owe[i], oa[i], ow[i], (n == 2 && i == 0));
        end
      end
      exp_wbv = 0;
      if (n > 0) begin
        if (owe[i]) begin
          rmem[oa[i][7:0]] = ow[i];
        end else begin
          exp_wbv = 1; exp_port = opt[i]; exp_reg = org[i];
          exp_data = rmem[oa[i][7:0]];
        end
      end
      if (n == 2 && i == 0 && exp_cnt < 65535) exp_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1; req0 = 1; req1 = 1; en1 = 1; we0 = 0; we1 = 0;
    addr0 = 32'h40; addr1 = 32'h44;
    #1;
    checks++;
    if (mem_en !== 0 || stall !== 0) begin
      errors++;
      $display("FAIL reset_bus got en=%0b st=%0b want 0 0", mem_en, stall);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (wb_valid !== 0 || wb_port !== 0 || wb_reg !== 0 ||
        wb_data !== 0 || conflict_cnt !== 0) begin
      errors++;
      $display("FAIL reset_regs got v=%0b p=%0b r=%0d d=%h c=%h want 0",
               wb_valid, wb_port, wb_reg, wb_data, conflict_cnt);
    end
    rst = 0; req0 = 0; req1 = 0; en1 = 0;
    exp_wbv = 0; exp_cnt = 0;
  endtask

  task automatic test_single_load();
    set_b(1, 0, 0, 1, 0, 32'h10, 0, 32'hA5, 0, 0, 0);
    run_bundle();
    set_b(1, 0, 0, 0, 0, 32'h10, 0, 0, 0, 5'd3, 0);
    run_bundle();
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_bundle();
  endtask

  task automatic test_store_load_pair();
    set_b(1, 1, 1, 1, 0, 32'h20, 32'h20, 32'h11, 0, 0, 5'd7);
    run_bundle();
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_bundle();
  endtask

  task automatic test_en1_off();
    set_b(1, 1, 0, 1, 0, 32'h20, 32'h20, 32'h22, 0, 0, 5'd7);
    run_bundle();
    set_b(0, 1, 0, 0, 0, 0, 32'h20, 0, 0, 0, 5'd9);
    run_bundle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      set_b(0, 1, 1, 0, 0, 0, 32'h20 + 32'(k * 4), 0, 0, 0, 5'(10 + k));
      run_bundle();
    end
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_bundle();
  endtask

  task automatic test_rst_second();
    logic [31:0] d;
    d = ~rmem[8'h30];
    req0 = 1; we0 = 0; addr0 = 32'h34; rd0 = 5'd4;
    req1 = 1; en1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = d; rd1 = 0;
    #1;
    checks++;
    if (stall !== 1 || mem_en !== 1) begin
      errors++;
      $display("FAIL rst2_first got st=%0b en=%0b want 1 1", stall, mem_en);
    end
    @(posedge clk); @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (mem_en !== 0 || stall !== 0) begin
      errors++;
      $display("FAIL rst2_bus got en=%0b st=%0b want 0 0", mem_en, stall);
    end
    @(posedge clk); @(negedge clk);
    rst = 0; req0 = 0; req1 = 0; en1 = 0;
    #1;
    checks++;
    if (mem_en !== 0 || wb_valid !== 0 || conflict_cnt !== 0 ||
        tmem[8'h30] !== rmem[8'h30]) begin
      errors++;
      $display("FAIL rst2_after got en=%0b v=%0b c=%h m=%h want 0 0 0 %h",
               mem_en, wb_valid, conflict_cnt, tmem[8'h30], rmem[8'h30]);
    end
    exp_wbv = 0; exp_cnt = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      set_b(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom),
            $urandom & 32'hFFFF_FF3C, $urandom & 32'hFFFF_FF3C,
            $urandom, $urandom, 5'($urandom), 5'($urandom));
      run_bundle();
    end
  endtask

  task automatic test_saturate();
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    exp_cnt = 65534;
    for (int k = 0; k < 3; k++) begin
      set_b(1, 1, 1, 1, 1, 32'h50, 32'h54, $urandom, $urandom, 0, 0);
      run_bundle();
    end
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_bundle();
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_single_load();
    test_store_load_pair();
    test_en1_off();
    test_back_to_back();
    test_rst_second();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
